// File: rtl/game_soc_led_seq_pkg.sv
// game_soc_led_seq_pkg: register map, bit positions and sequencer states
// shared by the LED sequencer and its timer.
package game_soc_led_seq_pkg;
    localparam logic [4:0] A_CTRL    = 5'd0;
    localparam logic [4:0] A_PERIOD  = 5'd1;
    localparam logic [4:0] A_LENGTH  = 5'd2;
    localparam logic [4:0] A_DIRECT  = 5'd3;
    localparam logic [4:0] A_STATUS  = 5'd4;
    localparam logic [4:0] A_PATTERN = 5'd16;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int STATUS_DONE = 8;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} seq_state_t;
endpackage

// File: rtl/game_soc_led_seq_timer.sv
// game_soc_led_seq_timer: loadable down-counter that flags expiry while enabled
// and holding zero.
module game_soc_led_seq_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] value,
    output logic             expire
);
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (en && cnt != '0) cnt <= cnt - DIV_W'(1);
    end

    assign expire = en && cnt == '0;
endmodule

// File: rtl/game_soc_led_sequencer.sv
// game_soc_led_sequencer: shares the LED PIO write port between direct CPU writes
// and a timed pattern sequencer driven from a small programmable table.
module game_soc_led_sequencer
    import game_soc_led_seq_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int DIV_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    output logic        busy
);
    localparam int IDX_W = $clog2(DEPTH);

    seq_state_t       state;
    logic [WIDTH-1:0] pattern [DEPTH];
    logic [DIV_W-1:0] period;
    logic [31:0]      length;
    logic [IDX_W-1:0] idx, last, next_idx, load_idx, pat_idx;
    logic [4:0]       pat_off;
    logic             loop, done, wr, ctrl_wr, start, stop, expire, step, reload, direct, pat_hit;

    assign wr       = s_chipselect && !s_write_n;
    assign ctrl_wr  = wr && s_address == A_CTRL;
    assign start    = ctrl_wr && s_writedata[CTRL_RUN];
    assign stop     = ctrl_wr && !s_writedata[CTRL_RUN];
    assign busy     = state != IDLE;
    // any CTRL write overrides a step expiring in the same cycle
    assign step     = busy && expire && !ctrl_wr;
    assign last     = length == 0 ? '0 : length > 32'(DEPTH) ? IDX_W'(DEPTH - 1) : IDX_W'(length - 32'd1);
    assign next_idx = idx < last ? idx + IDX_W'(1) : '0;
    assign reload   = start || (step && (idx < last || loop));
    assign load_idx = start ? '0 : next_idx;
    assign direct   = wr && s_address == A_DIRECT && !busy;
    assign pat_off  = s_address - A_PATTERN;
    assign pat_hit  = s_address >= A_PATTERN && pat_off < 5'(DEPTH);
    assign pat_idx  = pat_off[IDX_W-1:0];
    assign m_address = 2'b00;

    game_soc_led_seq_timer #(.DIV_W(DIV_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (reload),
        .en      (busy),
        .value   (period),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        else if (wr && pat_hit) pattern[pat_idx] <= s_writedata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            loop         <= 1'b0;
            done         <= 1'b0;
            period       <= '0;
            length       <= 32'(DEPTH);
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            m_chipselect <= reload || direct;
            m_write_n    <= !(reload || direct);
            if (reload) m_writedata <= 32'(pattern[load_idx]);
            else if (direct) m_writedata <= 32'(s_writedata[WIDTH-1:0]);
            if (wr && s_address == A_PERIOD) period <= s_writedata[DIV_W-1:0];
            if (wr && s_address == A_LENGTH) length <= s_writedata;
            if (ctrl_wr) loop <= s_writedata[CTRL_LOOP];
            if (step && !reload) done <= 1'b1;
            else if (wr && s_address == A_STATUS && s_writedata[STATUS_DONE]) done <= 1'b0;
            if (reload) idx <= load_idx;
            state <= reload ? LOAD : (stop || step) ? IDLE : busy ? WAIT : IDLE;
        end
    end

    assign s_readdata = pat_hit                ? 32'(pattern[pat_idx]) :
                        s_address == A_CTRL    ? {30'd0, loop, busy} :
                        s_address == A_PERIOD  ? 32'(period) :
                        s_address == A_LENGTH  ? length :
                        s_address == A_DIRECT  ? m_writedata :
                        s_address == A_STATUS  ? {23'd0, done, 4'd0, 4'(idx)} : 32'd0;
endmodule

// File: tb/tb_game_soc_led_sequencer.sv
// tb_game_soc_led_sequencer: randomized runs of the LED sequencer checked against
// a strobe schedule computed arithmetically from the programmed table, period and length.
module tb_game_soc_led_sequencer;
    localparam int WIDTH = 14;
    localparam int DEPTH = 8;
    localparam int DIV_W = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        busy;

    int          cyc = 0;
    int          wr_cyc;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] tbl [DEPTH];

    game_soc_led_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (m_chipselect) begin
            cyc_q.push_back(cyc);
            dat_q.push_back(m_writedata);
            check("m_write_n_strobe", 32'(m_write_n), 0);
            check("m_address", 32'(m_address), 0);
        end else if (!m_write_n) check("m_write_n_idle", 32'(m_write_n), 1);
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        s_address = a; s_chipselect = 1'b1; s_write_n = 1'b0; s_writedata = d; wr_cyc = cyc;
        @(posedge clk); #1;
        s_chipselect = 1'b0; s_write_n = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        s_address = a; s_chipselect = 1'b1;
        #1 d = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic run_case(input int p, input int lraw, input bit lp, input int stop_at, input bit fixed, input bit mid);
        int t, s, l, n, c, e, pw_cyc;
        logic [31:0] v, r, last_v;
        l = lraw == 0 ? 1 : lraw > DEPTH ? DEPTH : lraw;
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i] = fixed ? 32'(1 << i) : 32'($urandom_range(0, (1 << WIDTH) - 1));
            wr(5'(16 + i), tbl[i]);
        end
        wr(5'd1, p);
        wr(5'd2, lraw);
        cyc_q.delete(); dat_q.delete();
        pw_cyc = 32'h7fffffff;
        wr(5'd0, lp ? 32'd3 : 32'd1);
        t = wr_cyc;
        check("busy_start", 32'(busy), 1);
        if (mid) begin
            wr(5'd17, 32'h80);
            pw_cyc = wr_cyc;
            wr(5'd3, 32'h3fff);
        end
        if (lp) begin
            while (cyc < t + stop_at - 1) begin @(posedge clk); #1; end
            wr(5'd0, 32'd0);
            s = wr_cyc;
            check("busy_stop", 32'(busy), 0);
        end else begin
            s = 32'h7fffffff;
            repeat (l * (p + 1) + 2) @(posedge clk);
            #1 check("busy_end", 32'(busy), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        last_v = '0;
        for (int k = 0; k < 2000; k++) begin
            c = t + 1 + k * (p + 1);
            if (lp ? c > s : k >= l) break;
            e = k % l;
            v = (mid && e == 1 && c - 1 > pw_cyc) ? 32'h80 : tbl[e];
            if (n < cyc_q.size()) begin
                check("strobe_cycle", cyc_q[n], c);
                check("strobe_data", dat_q[n], v);
            end
            last_v = v;
            n++;
        end
        check("strobe_count", cyc_q.size(), n);
        rd(5'd3, r);
        check("direct_readback", r, last_v);
        rd(5'd4, r);
        check("status", r, lp ? 32'((n - 1) % l) : 32'h100 | 32'(l - 1));
        if (!lp) begin
            wr(5'd4, 32'h100);
            rd(5'd4, r);
            check("status_cleared", r, 32'(l - 1));
        end
    endtask

    initial begin
        logic [31:0] r, d;
        int t;
        #12;
        check("rst_cs", 32'(m_chipselect), 0);
        check("rst_write_n", 32'(m_write_n), 1);
        check("rst_wdata", m_writedata, 0);
        check("rst_busy", 32'(busy), 0);
        #11 reset_n = 1'b1;
        rd(5'd2, r); check("rst_length", r, DEPTH);
        rd(5'd4, r); check("rst_status", r, 0);
        rd(5'd1, r); check("rst_period", r, 0);
        rd(5'd0, r); check("rst_ctrl", r, 0);
        rd(5'd9, r); check("unmapped", r, 0);

        for (int i = 0; i < 4; i++) begin
            d = i == 0 ? 32'h155 : $urandom;
            cyc_q.delete(); dat_q.delete();
            wr(5'd3, d);
            t = wr_cyc;
            repeat (3) @(posedge clk);
            #1 check("direct_count", cyc_q.size(), 1);
            if (cyc_q.size() > 0) begin
                check("direct_cycle", cyc_q[0], t + 1);
                check("direct_data", dat_q[0], d & 32'h3fff);
            end
            rd(5'd3, r);
            check("direct_read", r, d & 32'h3fff);
        end

        run_case(4, 3, 0, 0, 1, 0);
        run_case(4, 3, 1, 17, 1, 0);
        run_case(4, 3, 1, 17, 1, 1);
        run_case(4, 3, 1, 5, 1, 0);
        run_case(2, 0, 1, 12, 0, 0);
        run_case(3, 0, 0, 0, 0, 0);
        run_case(0, 2, 0, 0, 0, 0);
        run_case(0, 12, 1, 20, 0, 0);
        for (int i = 0; i < 10; i++)
            run_case($urandom_range(0, 5), $urandom_range(0, 11), 1'($urandom_range(0, 1)),
                     $urandom_range(2, 40), 0, 0);

        run_case(20, 3, 0, 0, 0, 0);
        wr(5'd0, 32'd3);
        check("cs_before_reset", 32'(m_chipselect), 1);
        reset_n = 1'b0;
        #1;
        check("arst_cs", 32'(m_chipselect), 0);
        check("arst_write_n", 32'(m_write_n), 1);
        check("arst_wdata", m_writedata, 0);
        check("arst_busy", 32'(busy), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd(5'd4, r); check("arst_status", r, 0);
        rd(5'd2, r); check("arst_length", r, DEPTH);
        rd(5'd1, r); check("arst_period", r, 0);
        rd(5'd16, r); check("arst_pattern0", r, 0);
        cyc_q.delete(); dat_q.delete();
        repeat (30) @(posedge clk);
        #1 check("arst_no_strobe", cyc_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
